// File: rtl/seq_div.sv
// seq_div: sequential signed divider using a radix-2 restoring algorithm.
// The divider works on operand magnitudes and produces one quotient bit per clock.
// Signs are applied in a final fix-up cycle. The quotient truncates toward zero.
// The remainder carries the sign of the dividend.
// Operands are registered on start, and results are registered and held.
module seq_div #(
    parameter int WORD_LEN = 8
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_start,
    input  logic [WORD_LEN-1:0] i_dividend,
    input  logic [WORD_LEN-1:0] i_divisor,
    output logic                o_busy,
    output logic                o_done,
    output logic [WORD_LEN-1:0] o_quotient,
    output logic [WORD_LEN-1:0] o_remainder,
    output logic                o_div_by_zero
);

    localparam int CW = $clog2(WORD_LEN + 1);
    localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]       CNT_LAST = CW'(WORD_LEN - 1);
    localparam logic [WORD_LEN-1:0] ONE      = WORD_LEN'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t              state_reg;
    logic [CW-1:0]       cnt_reg;
    logic [WORD_LEN-1:0] rem_reg;      // running remainder, always < divisor magnitude
    logic [WORD_LEN-1:0] dvd_reg;      // dividend magnitude; quotient bits shift in at the bottom
    logic [WORD_LEN-1:0] dsr_reg;      // divisor magnitude
    logic [WORD_LEN-1:0] raw_dvd_reg;  // original dividend, returned as remainder on divide by zero
    logic                sign_q_reg;
    logic                sign_r_reg;
    logic                zero_reg;

    logic [WORD_LEN-1:0] dvd_mag;
    logic [WORD_LEN-1:0] dsr_mag;
    logic [WORD_LEN:0]   shifted;
    logic [WORD_LEN:0]   trial;
    logic                q_bit;
    logic [WORD_LEN-1:0] neg_q;
    logic [WORD_LEN-1:0] neg_r;

    // The magnitude of -2^(WORD_LEN-1) is still representable as an unsigned WORD_LEN value.
    assign dvd_mag = i_dividend[WORD_LEN-1] ? (~i_dividend + ONE) : i_dividend;
    assign dsr_mag = i_divisor[WORD_LEN-1]  ? (~i_divisor + ONE)  : i_divisor;

    // One restoring step.
    // The (WORD_LEN+1)-bit shifted remainder is compared against the divisor through the sign of the difference.
    assign shifted = {rem_reg, dvd_reg[WORD_LEN-1]};
    assign trial   = shifted - {1'b0, dsr_reg};
    assign q_bit   = ~trial[WORD_LEN];

    assign neg_q = ~dvd_reg + ONE;
    assign neg_r = ~rem_reg + ONE;

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            raw_dvd_reg   <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            zero_reg      <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        dvd_reg     <= dvd_mag;
                        dsr_reg     <= dsr_mag;
                        raw_dvd_reg <= i_dividend;
                        sign_q_reg  <= i_dividend[WORD_LEN-1] ^ i_divisor[WORD_LEN-1];
                        sign_r_reg  <= i_dividend[WORD_LEN-1];
                        zero_reg    <= (i_divisor == '0);
                        rem_reg     <= '0;
                        cnt_reg     <= '0;
                        o_busy      <= 1'b1;
                        state_reg   <= CALC;
                    end
                end
                CALC: begin
                    // When no subtraction happens, shifted < divisor, so the low WORD_LEN bits hold the whole remainder.
                    rem_reg <= q_bit ? trial[WORD_LEN-1:0] : shifted[WORD_LEN-1:0];
                    dvd_reg <= {dvd_reg[WORD_LEN-2:0], q_bit};
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                FIX: begin
                    if (zero_reg) begin
                        o_quotient    <= '1;
                        o_remainder   <= raw_dvd_reg;
                        o_div_by_zero <= 1'b1;
                    end else begin
                        o_quotient    <= sign_q_reg ? neg_q : dvd_reg;
                        o_remainder   <= sign_r_reg ? neg_r : rem_reg;
                        o_div_by_zero <= 1'b0;
                    end
                    o_done    <= 1'b1;
                    o_busy    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Testbench for seq_div.
// Vectors come from a table and a signed-division model.
// Expected results go through a scoreboard queue.
module tb_seq_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dvd = '0;
    logic [W-1:0] dsr = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;

    always #5 clk = ~clk;

    seq_div #(.WORD_LEN(W)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_start       (start),
        .i_dividend    (dvd),
        .i_divisor     (dsr),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quo),
        .o_remainder   (rem),
        .o_div_by_zero (dz)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Drive a start at the current negedge.
    // Return at the negedge after the accepting edge, then scramble the operand inputs.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        exp_t e;
        e.q = q;
        e.r = r;
        e.z = z;
        dvd = a;
        dsr = b;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dvd = W'($urandom);
        dsr = W'($urandom);
        check("busy_after_accept", int'(busy), 1);
    endtask

    // Wait for o_done. Count edges since the accepting edge, starting from n0.
    // Compare the latency and the popped expectation.
    task automatic await_done(input string name, input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!done) begin
            check({name, "_timeout"}, 0, 1);
            sb.delete();
        end else begin
            check({name, "_latency"}, n, W + 1);
            check({name, "_busy_low"}, int'(busy), 0);
            if (sb.size() == 0) begin
                check({name, "_unexpected_done"}, 1, 0);
            end else begin
                e = sb.pop_front();
                check({name, "_q"}, int'(quo), int'(e.q));
                check({name, "_r"}, int'(rem), int'(e.r));
                check({name, "_dz"}, int'(dz), int'(e.z));
                $display("op %s: q=%h r=%h dz=%0d lat=%0d", name, quo, rem, dz, n);
            end
        end
    endtask

    task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        vec_t v;
        v.a = a;
        v.b = b;
        v.q = q;
        v.r = r;
        v.z = z;
        vecs.push_back(v);
    endtask

    initial begin
        int           sa;
        int           sbv;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           dones;
        vec_t         v;

        // Fixed table of specified cases.
        add_vec(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0);   //  100 /  7
        add_vec(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0);   // -100 /  7
        add_vec(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0);   //  100 / -7
        add_vec(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0);   // -100 / -7
        add_vec(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);   // -128 / -1 wraps
        add_vec(8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0);   //  127 /  1
        add_vec(8'h03, 8'h05, 8'h00, 8'h03, 1'b0);   //    3 /  5
        add_vec(8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0);   // -128 / 127
        add_vec(8'h05, 8'h00, 8'hFF, 8'h05, 1'b1);   //    5 /  0
        add_vec(8'h09, 8'h03, 8'h03, 8'h00, 1'b0);   //    9 /  3 clears dz
        // Random nonzero-divisor cases from a truncating signed model.
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(1, 255));
            sa = int'($signed(ra));
            sbv = int'($signed(rb));
            add_vec(ra, rb, W'(sa / sbv), W'(sa % sbv), 1'b0);
        end

        // Reset state.
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(quo), 0);
        check("rst_r", int'(rem), 0);
        check("rst_dz", int'(dz), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Table-driven vectors, each followed by a check that o_done lasts one cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            issue(v.a, v.b, v.q, v.r, v.z);
            await_done($sformatf("vec%0d", i), 0);
            @(posedge clk);
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
            check("q_held", int'(quo), int'(v.q));
        end

        // A start pulsed during CALC is ignored. A start in the o_done cycle is accepted.
        issue(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        dvd = 8'h01;
        dsr = 8'h01;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        await_done("ignore_start", 4);
        issue(8'h32, 8'h06, 8'h08, 8'h02, 1'b0);
        await_done("back_to_back", 0);

        // Reset during CALC cycle 4 aborts the operation asynchronously.
        @(negedge clk);
        issue(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rstn = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        check("async_q", int'(quo), 0);
        check("async_r", int'(rem), 0);
        check("async_dz", int'(dz), 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        dones = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_abort", dones, 0);
        issue(8'h32, 8'h06, 8'h08, 8'h02, 1'b0);
        await_done("after_reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential signed integer divider: the inverse operation to the team's registered radix-4 Booth multiplier and the companion block for datapaths that must undo a scaling product (e.g. normalisation of correlator outputs). It accepts one two's-complement dividend/divisor pair per start pulse and runs a radix-2 restoring algorithm on operand magnitudes, one quotient bit per clock. It returns a quotient truncated toward zero and a remainder, then pulses done. Operands are registered on start and results are registered and held, so the block is fully registered at both boundaries.

## Interface
- WORD_LEN, 8, operand/result width in bits; must be even and at least 4.

- i_clk  in  1  clock; all state changes on the rising edge.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_start  in  1  request; sampled only in IDLE.
- i_dividend  in  WORD_LEN  signed dividend; captured on the accepting edge.
- i_divisor  in  WORD_LEN  signed divisor; captured on the accepting edge.
- o_busy  out  1  high while a division is in progress; starts are ignored.
- o_done  out  1  one-cycle pulse; results valid.
- o_quotient  out  WORD_LEN  signed quotient; held until the next o_done.
- o_remainder  out  WORD_LEN  signed remainder; held until the next o_done.
- o_div_by_zero  out  1  set with o_done when the divisor was 0; held until the next o_done.

## Operation
- States:
  - IDLE → CALC when i_start=1.
  - CALC runs exactly WORD_LEN cycles, counted by a bit counter, then → FIX.
  - FIX → IDLE after one cycle.
- Accept (edge in IDLE with i_start=1):
  - register |dividend| and |divisor| as WORD_LEN-bit unsigned magnitudes.
  - register sign_q = dividend[MSB] XOR divisor[MSB] and sign_r = dividend[MSB].
  - register a divisor-is-zero flag.
  - clear the (WORD_LEN+1)-bit partial remainder.
- CALC, each cycle:
  - shift {partial remainder, dividend magnitude} left by 1.
  - trial = partial remainder − divisor magnitude, computed at WORD_LEN+1 bits.
  - if trial ≥ 0, keep trial and shift in quotient bit 1; otherwise keep the old value and shift in 0.
- FIX edge (registers outputs, asserts o_done for one cycle):
  - o_quotient = sign_q ? −q_mag : q_mag.
  - o_remainder = sign_r ? −r_mag : r_mag.
  - both are truncated to WORD_LEN bits.
- Semantics: quotient rounds toward zero; the remainder is 0 or takes the sign of the dividend; dividend = quotient·divisor + remainder.
- Overflow: dividend = −2^(WORD_LEN−1) with divisor = −1 wraps to quotient −2^(WORD_LEN−1) and remainder 0. No flag is raised.
- Divide by zero:
  - latency is unchanged.
  - FIX forces o_quotient to all ones, o_remainder to the captured dividend unchanged, and o_div_by_zero=1.
- o_div_by_zero is cleared by the next non-zero-divisor completion.
- i_start while o_busy=1 is ignored; the captured operands are not disturbed.

## Timing
- Reset values, and the values forced immediately on asynchronous reset: state IDLE, o_busy=0, o_done=0, o_quotient=0, o_remainder=0, o_div_by_zero=0, counter 0.
- Latency, with edge 0 as the edge that accepts i_start:
  - o_busy is high from after edge 0 until edge WORD_LEN+1.
  - o_done is high for exactly the cycle after edge WORD_LEN+1.
- Throughput: a new i_start may be accepted on the edge ending the o_done cycle (state is IDLE), giving one result per WORD_LEN+2 cycles back-to-back.
- Reset mid-CALC or mid-FIX aborts the operation. No o_done is produced for it.
- Outputs change only on the FIX edge or on reset.

## Test plan
- WORD_LEN=8, i_dividend=100, i_divisor=7, start at edge 0:
  - o_done only after edge 9.
  - o_quotient=8'h0E, o_remainder=8'h02, o_div_by_zero=0.
- Sign combinations:
  - −100/7 → 8'hF2 / 8'hFE.
  - 100/−7 → 8'hF2 / 8'h02.
  - −100/−7 → 8'h0E / 8'hFE.
- Corners:
  - −128/−1 → 8'h80 / 8'h00.
  - 127/1 → 8'h7F / 8'h00.
  - 3/5 → 8'h00 / 8'h03.
  - −128/127 → 8'hFF / 8'hFF.
- 5/0:
  - o_quotient=8'hFF, o_remainder=8'h05, o_div_by_zero=1, same latency.
  - a following 9/3 → 8'h03 / 8'h00 with o_div_by_zero cleared.
- i_start with new operands pulsed during CALC:
  - ignored; the first result is unaffected.
  - a start in the o_done cycle is accepted, and its o_done arrives exactly 10 cycles later.
- Assert i_rstn=0 at CALC cycle 4:
  - all outputs read 0 immediately.
  - no o_done follows.
  - after release, 50/6 → 8'h08 / 8'h02.
